// File: rtl/settings_ctrl_pkg.sv
// Shared widths, mode codes and key-FSM encoding for the settings controller.
package settings_ctrl_pkg;

  localparam int VOL_W = 4;
  localparam int LVL_W = 3;
  localparam int CNT_W = 25;

  localparam logic [1:0] STATE_GAME   = 2'd0;
  localparam logic [1:0] STATE_VOLUME = 2'd1;
  localparam logic [1:0] STATE_LEVEL  = 2'd2;

  typedef enum logic [1:0] {
    KEY_IDLE     = 2'd0,
    KEY_HOLD     = 2'd1,
    KEY_REPEAT   = 2'd2,
    KEY_WAIT_REL = 2'd3
  } key_state_t;

endpackage

// File: rtl/settings_ctrl_key_repeat.sv
// Key edge detect plus hold/auto-repeat FSM; emits one-cycle step_up/step_down pulses.
module settings_ctrl_key_repeat
  import settings_ctrl_pkg::*;
#(
  parameter int HOLD_CYC   = 25000000,
  parameter int REPEAT_CYC = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic mode_chg,
  output logic step_up,
  output logic step_down
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

  key_state_t       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             up_q_r, down_q_r;
  logic             sel_up_r, sel_up_s;
  logic             rise_up_s, rise_down_s, held_s, other_s;
  logic [CNT_W-1:0] last_s;

  // Key copies reset high so a key held through reset never looks like a new press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= KEY_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      up_q_r   <= 1'b1;
      down_q_r <= 1'b1;
      sel_up_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      up_q_r   <= btn_up;
      down_q_r <= btn_down;
      sel_up_r <= sel_up_s;
    end
  end

  assign rise_up_s   = btn_up & ~up_q_r;
  assign rise_down_s = btn_down & ~down_q_r;
  assign held_s      = sel_up_r ? btn_up : btn_down;
  assign other_s     = sel_up_r ? btn_down : btn_up;
  assign last_s      = (state_r == KEY_HOLD) ? HOLD_LAST : REPEAT_LAST;

  // Next-state, counter and step pulses.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    sel_up_s  = sel_up_r;
    step_up   = 1'b0;
    step_down = 1'b0;
    case (state_r)
      KEY_IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        if (btn_up && btn_down) begin
          state_s = KEY_WAIT_REL;
        end else if (rise_up_s) begin
          step_up  = 1'b1;
          sel_up_s = 1'b1;
          state_s  = KEY_HOLD;
        end else if (rise_down_s) begin
          step_down = 1'b1;
          sel_up_s  = 1'b0;
          state_s   = KEY_HOLD;
        end else begin
          state_s = KEY_IDLE;
        end
      end
      KEY_HOLD, KEY_REPEAT: begin
        if (mode_chg || other_s) begin
          state_s = KEY_WAIT_REL;
          cnt_s   = {CNT_W{1'b0}};
        end else if (!held_s) begin
          state_s = KEY_IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == last_s) begin
          step_up   = sel_up_r;
          step_down = ~sel_up_r;
          state_s   = KEY_REPEAT;
          cnt_s     = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      KEY_WAIT_REL: begin
        if (!btn_up && !btn_down) begin
          state_s = KEY_IDLE;
        end else begin
          state_s = KEY_WAIT_REL;
        end
      end
      default: begin
        state_s = KEY_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/settings_ctrl.sv
// Applies key steps to volume or level depending on mode, and drives the req/ack beep.
module settings_ctrl
  import settings_ctrl_pkg::*;
#(
  parameter int VOL_MAX    = 15,
  parameter int VOL_RST    = 8,
  parameter int LVL_MAX    = 4,
  parameter int LVL_RST    = 1,
  parameter int HOLD_CYC   = 25000000,
  parameter int REPEAT_CYC = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       state,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             game_active,
  output logic [VOL_W-1:0] volume,
  output logic [LVL_W-1:0] level,
  output logic             beep_req,
  output logic             beep_tone,
  input  logic             beep_ack
);

  localparam logic [VOL_W-1:0] VOL_TOP  = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0] VOL_INIT = VOL_W'(VOL_RST);
  localparam logic [LVL_W-1:0] LVL_TOP  = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] LVL_INIT = LVL_W'(LVL_RST);
  localparam logic [LVL_W-1:0] LVL_MIN  = LVL_W'(1);

  logic [1:0]       state_r;
  logic             mode_chg_s, step_up_s, step_down_s, step_s, refused_s;
  logic [VOL_W-1:0] volume_s;
  logic [LVL_W-1:0] level_s;
  logic             beep_req_s, beep_tone_s;

  assign mode_chg_s = (state != state_r);

  settings_ctrl_key_repeat #(
    .HOLD_CYC   (HOLD_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_key_repeat (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .mode_chg  (mode_chg_s),
    .step_up   (step_up_s),
    .step_down (step_down_s)
  );

  // Setting update for the current mode; refused steps still count as beep events.
  always_comb begin
    volume_s  = volume;
    level_s   = level;
    step_s    = 1'b0;
    refused_s = 1'b0;
    case (state)
      STATE_VOLUME: begin
        if (step_up_s) begin
          step_s = 1'b1;
          if (volume == VOL_TOP) refused_s = 1'b1;
          else                   volume_s  = volume + VOL_W'(1);
        end else if (step_down_s) begin
          step_s = 1'b1;
          if (volume == {VOL_W{1'b0}}) refused_s = 1'b1;
          else                         volume_s  = volume - VOL_W'(1);
        end else begin
          step_s = 1'b0;
        end
      end
      STATE_LEVEL: begin
        if (step_up_s || step_down_s) begin
          step_s = 1'b1;
          if (game_active)                         refused_s = 1'b1;
          else if (step_up_s && level == LVL_TOP)  refused_s = 1'b1;
          else if (step_up_s)                      level_s   = level + LVL_W'(1);
          else if (level == LVL_MIN)               refused_s = 1'b1;
          else                                     level_s   = level - LVL_W'(1);
        end else begin
          step_s = 1'b0;
        end
      end
      default: begin
        step_s = 1'b0;
      end
    endcase
  end

  // An ack retires the pending beep; a coinciding step starts a fresh one instead.
  always_comb begin
    beep_req_s  = beep_req;
    beep_tone_s = beep_tone;
    if (step_s) begin
      if (!beep_req || beep_ack) begin
        beep_req_s  = 1'b1;
        beep_tone_s = refused_s;
      end else begin
        beep_tone_s = beep_tone | refused_s;
      end
    end else if (beep_ack) begin
      beep_req_s = 1'b0;
    end else begin
      beep_req_s = beep_req;
    end
  end

  // Output and mode-history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      volume    <= VOL_INIT;
      level     <= LVL_INIT;
      beep_req  <= 1'b0;
      beep_tone <= 1'b0;
      state_r   <= STATE_GAME;
    end else begin
      volume    <= volume_s;
      level     <= level_s;
      beep_req  <= beep_req_s;
      beep_tone <= beep_tone_s;
      state_r   <= state;
    end
  end

endmodule

// File: tb/tb_settings_ctrl.sv
// Scoreboard bench for settings_ctrl: expected beeps are queued with the stimulus and checked on each beep_req.
module tb_settings_ctrl;
  import settings_ctrl_pkg::*;

  typedef struct {
    logic [3:0] vol;
    logic [2:0] lvl;
    logic       tone;
  } beep_t;

  logic       clk, rst, btn_up, btn_down, game_active, beep_ack;
  logic [1:0] state;
  logic [3:0] volume;
  logic [2:0] level;
  logic       beep_req, beep_tone;

  int    vectors, miscompares;
  bit    auto_ack;
  beep_t exp_q[$];

  settings_ctrl #(
    .VOL_MAX(15), .VOL_RST(8), .LVL_MAX(4), .LVL_RST(1),
    .HOLD_CYC(20), .REPEAT_CYC(5)
  ) dut (
    .clk(clk), .rst(rst), .state(state), .btn_up(btn_up), .btn_down(btn_down),
    .game_active(game_active), .volume(volume), .level(level),
    .beep_req(beep_req), .beep_tone(beep_tone), .beep_ack(beep_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_beep(input int v, input int l, input bit t);
    beep_t b;
    b.vol = 4'(v); b.lvl = 3'(l); b.tone = t;
    exp_q.push_back(b);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tap(input bit up);
    if (up) btn_up = 1'b1; else btn_down = 1'b1;
    cycles(3);
    btn_up = 1'b0; btn_down = 1'b0;
    cycles(6);
  endtask

  // Audio-block model: acknowledges each beep and checks it against the scoreboard.
  initial begin
    beep_t e;
    beep_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack && beep_req === 1'b1) begin
        check_val("beep_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_val("beep_tone", beep_tone, e.tone);
          check_val("beep_volume", volume, e.vol);
          check_val("beep_level", level, e.lvl);
        end
        beep_ack = 1'b1;
        @(negedge clk);
        beep_ack = 1'b0;
        check_val("req_drop", beep_req, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0; auto_ack = 1'b1;
    rst = 1'b1; state = STATE_VOLUME; btn_up = 1'b0; btn_down = 1'b0; game_active = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    check_val("rst_volume", volume, 8);
    check_val("rst_level", level, 1);
    check_val("rst_req", beep_req, 0);
    check_val("rst_tone", beep_tone, 0);

    // 1: single tap up
    push_beep(9, 1, 1'b0);
    tap(1'b1);
    check_val("t1_volume", volume, 9);
    check_val("t1_pending", exp_q.size(), 0);

    // 2: hold up 60 cycles: steps at 0,20,25..55 -> 10..15 then three refused
    for (int v = 10; v <= 15; v++) push_beep(v, 1, 1'b0);
    for (int i = 0; i < 3; i++) push_beep(15, 1, 1'b1);
    btn_up = 1'b1;
    cycles(60);
    btn_up = 1'b0;
    cycles(6);
    check_val("t2_volume", volume, 15);
    check_val("t2_pending", exp_q.size(), 0);

    // 3: level mode, locked then saturated then accepted
    state = STATE_LEVEL; game_active = 1'b1;
    cycles(2);
    push_beep(15, 1, 1'b1);
    tap(1'b1);
    check_val("t3_locked_level", level, 1);
    game_active = 1'b0;
    push_beep(15, 1, 1'b1);
    tap(1'b0);
    check_val("t3_floor_level", level, 1);
    push_beep(15, 2, 1'b0);
    tap(1'b1);
    check_val("t3_level", level, 2);
    check_val("t3_pending", exp_q.size(), 0);

    // 4: game mode ignores keys; both keys in volume mode give nothing until released
    state = STATE_GAME;
    cycles(2);
    btn_up = 1'b1;
    cycles(30);
    btn_up = 1'b0;
    tap(1'b0);
    btn_up = 1'b1; btn_down = 1'b1;
    cycles(5);
    btn_up = 1'b0; btn_down = 1'b0;
    cycles(3);
    check_val("t4_game_req", beep_req, 0);
    check_val("t4_game_volume", volume, 15);
    check_val("t4_game_level", level, 2);
    state = STATE_VOLUME;
    cycles(2);
    btn_up = 1'b1; btn_down = 1'b1;
    cycles(30);
    btn_down = 1'b0;
    cycles(10);
    btn_up = 1'b0;
    cycles(5);
    check_val("t4_both_req", beep_req, 0);
    check_val("t4_both_volume", volume, 15);
    push_beep(14, 2, 1'b0);
    tap(1'b0);
    check_val("t4_volume", volume, 14);

    // 5: mode switch mid-REPEAT must not carry the held key into level mode
    push_beep(15, 2, 1'b0);
    push_beep(15, 2, 1'b1);
    push_beep(15, 2, 1'b1);
    btn_up = 1'b1;
    cycles(27);
    state = STATE_LEVEL;
    cycles(30);
    check_val("t5_held_level", level, 2);
    btn_up = 1'b0;
    cycles(4);
    check_val("t5_pending", exp_q.size(), 0);
    push_beep(15, 3, 1'b0);
    tap(1'b1);
    check_val("t5_level", level, 3);

    // 6: async reset mid-REPEAT with a beep outstanding
    state = STATE_VOLUME;
    cycles(2);
    auto_ack = 1'b0;
    btn_up = 1'b1;
    cycles(27);
    check_val("t6_req_before", beep_req, 1);
    #3 rst = 1'b1;
    #1;
    check_val("t6_rst_volume", volume, 8);
    check_val("t6_rst_level", level, 1);
    check_val("t6_rst_req", beep_req, 0);
    check_val("t6_rst_tone", beep_tone, 0);
    cycles(2);
    rst = 1'b0;
    cycles(30);
    check_val("t6_held_req", beep_req, 0);
    check_val("t6_held_volume", volume, 8);
    btn_up = 1'b0;
    cycles(3);
    auto_ack = 1'b1;
    push_beep(9, 1, 1'b0);
    tap(1'b1);
    check_val("t6_volume", volume, 9);
    check_val("t6_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
